// File: rtl/matrix_pkg.sv
// Shared codes for the matrix bank and the multiply engine that drives its memory port.
package matrix_pkg;

  typedef enum logic [1:0] {
    TYPE_CELL = 2'b00,
    TYPE_ROW  = 2'b01,
    TYPE_COL  = 2'b10,
    TYPE_RSVD = 2'b11
  } req_type_e;

  typedef enum logic [1:0] {
    MAT_A       = 2'b00,
    MAT_B       = 2'b01,
    MAT_C       = 2'b10,
    MAT_INVALID = 2'b11
  } matrix_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GATHER  = 2'b01,
    ST_RESPOND = 2'b10
  } bank_state_e;

  // Latched description of an in-flight read request.
  typedef struct packed {
    req_type_e req_type;
    matrix_e   matrix;
  } req_kind_t;

  // Row and column reads gather size beats; everything else (incl. reserved type) is one cell.
  function automatic logic is_vector(input req_type_e t);
    return (t == TYPE_ROW) || (t == TYPE_COL);
  endfunction

endpackage

// File: rtl/matrix_cell_array.sv
// Storage for matrices A, B and C: combinational read port, synchronous write port, synchronous clear.
module matrix_cell_array #(
  parameter int unsigned size       = 4,
  parameter int unsigned cell_width = 16,
  parameter int unsigned idx_width  = $clog2(3 * size * size)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [idx_width-1:0]  rd_idx,
  input  logic                  rd_valid,
  output logic [cell_width-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [idx_width-1:0]  wr_idx,
  input  logic [cell_width-1:0] wr_data
);

  localparam int unsigned DEPTH = 3 * size * size;

  logic [cell_width-1:0] mem_q [DEPTH];
  logic [cell_width-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Out-of-range lookups read as zero rather than aliasing into another matrix.
  assign rd_data = rd_valid ? mem_q[rd_idx] : '0;

endmodule

// File: rtl/matrix_bank.sv
// Matrix storage/access stage: gathers cell, row or column reads one cell per beat, accepts single-cell writes.
// Optional range-error output is compiled in with MATRIX_BANK_RANGE_CHECK_EN.
module matrix_bank
  import matrix_pkg::*;
#(
  parameter int unsigned size          = 4,
  parameter int unsigned cell_width    = 16,
  parameter int unsigned address_width = 4,
  parameter int unsigned width         = cell_width * size
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic [address_width-1:0] in_address,
  input  logic [1:0]               in_type,
  input  logic [1:0]               in_matrix,
  input  logic                     in_read_en,
  input  logic                     in_write_en,
  input  logic [width-1:0]         in_data,
`ifdef MATRIX_BANK_RANGE_CHECK_EN
  output logic                     out_error,
`endif
  output logic [width-1:0]         out_data,
  output logic                     out_data_ready,
  output logic                     out_busy
);

  localparam int unsigned CELLS  = size * size;
  localparam int unsigned IDX_W  = $clog2(3 * CELLS);
  localparam int unsigned BEAT_W = $clog2(size) + 1;
  localparam int unsigned EXT_W  = address_width + $clog2(size) + 1;

  bank_state_e              state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  req_kind_t                kind_q, kind_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [width-1:0]         gather_q, gather_d;
  logic [width-1:0]         data_q, data_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;

  logic [EXT_W-1:0]         beat_addr_c;
  logic                     rd_valid_c;
  logic [IDX_W-1:0]         rd_idx_c;
  logic [cell_width-1:0]    rd_data_c;
  logic                     last_beat_c;
  logic                     wr_valid_c;
  logic [IDX_W-1:0]         wr_idx_c;
  logic                     unused_data_c;

  assign unused_data_c = ^in_data[width-1:cell_width];

  // Cell index of the current beat, kept wide enough that the range test sees any overflow.
  always_comb begin
    beat_addr_c = EXT_W'(addr_q);
    case (kind_q.req_type)
      TYPE_ROW: beat_addr_c = EXT_W'(addr_q) + EXT_W'(beat_q);
      TYPE_COL: beat_addr_c = EXT_W'(addr_q) + EXT_W'(beat_q) * EXT_W'(size);
      default:  beat_addr_c = EXT_W'(addr_q);
    endcase
  end

  assign rd_valid_c  = (beat_addr_c < EXT_W'(CELLS)) && (kind_q.matrix != MAT_INVALID);
  assign rd_idx_c    = IDX_W'(kind_q.matrix) * IDX_W'(CELLS) + IDX_W'(beat_addr_c);
  assign last_beat_c = is_vector(kind_q.req_type) ? (beat_q == BEAT_W'(size - 1)) : 1'b1;

  assign wr_valid_c  = in_write_en && (EXT_W'(in_address) < EXT_W'(CELLS))
                       && (in_matrix != 2'(MAT_INVALID));
  assign wr_idx_c    = IDX_W'(in_matrix) * IDX_W'(CELLS) + IDX_W'(in_address);

  matrix_cell_array #(
    .size       (size),
    .cell_width (cell_width),
    .idx_width  (IDX_W)
  ) u_cells (
    .clk      (in_clk),
    .reset    (in_reset),
    .rd_idx   (rd_idx_c),
    .rd_valid (rd_valid_c),
    .rd_data  (rd_data_c),
    .wr_en    (wr_valid_c),
    .wr_idx   (wr_idx_c),
    .wr_data  (in_data[cell_width-1:0])
  );

  // Request sequencing: accept in IDLE, one cell per GATHER beat, one-cycle RESPOND.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    kind_d   = kind_q;
    beat_d   = beat_q;
    gather_d = gather_q;
    data_d   = data_q;
    ready_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_read_en && !in_write_en) begin
          state_d         = ST_GATHER;
          addr_d          = in_address;
          kind_d.req_type = req_type_e'(in_type);
          kind_d.matrix   = matrix_e'(in_matrix);
          beat_d          = '0;
          gather_d        = '0;
        end
      end
      ST_GATHER: begin
        for (int unsigned k = 0; k < size; k++) begin
          if (beat_q == BEAT_W'(k)) begin
            gather_d[k*cell_width +: cell_width] = rd_data_c;
          end
        end
        if (last_beat_c) begin
          state_d = ST_RESPOND;
          ready_d = 1'b1;
          data_d  = gather_d;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      kind_q   <= '0;
      beat_q   <= '0;
      gather_q <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      kind_q   <= kind_d;
      beat_q   <= beat_d;
      gather_q <= gather_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign out_data       = data_q;
  assign out_data_ready = ready_q;
  assign out_busy       = busy_q;

`ifdef MATRIX_BANK_RANGE_CHECK_EN
  logic acc_err_q, acc_err_d;
  logic rd_err_q, rd_err_d;
  logic err_q, err_d;

  // Read error is a level held from the ready pulse until the next accepted request;
  // a dropped write adds a single-cycle pulse on top.
  always_comb begin
    acc_err_d = acc_err_q;
    rd_err_d  = rd_err_q;
    if (state_q == ST_IDLE && in_read_en && !in_write_en) begin
      acc_err_d = 1'b0;
      rd_err_d  = 1'b0;
    end else if (state_q == ST_GATHER) begin
      acc_err_d = acc_err_q | !rd_valid_c;
      if (last_beat_c) begin
        rd_err_d = acc_err_q | !rd_valid_c;
      end
    end
    err_d = rd_err_d | (in_write_en && !wr_valid_c);
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      acc_err_q <= 1'b0;
      rd_err_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      acc_err_q <= acc_err_d;
      rd_err_q  <= rd_err_d;
      err_q     <= err_d;
    end
  end

  assign out_error = err_q;
`endif

endmodule

// File: tb/tb_matrix_bank.sv
// Scoreboard bench for matrix_bank: directed reads/writes push expected responses, a monitor checks each ready pulse.
module tb_matrix_bank;
  import matrix_pkg::*;

  localparam int unsigned SIZE = 4;
  localparam int unsigned CW   = 16;
  localparam int unsigned AW   = 5;
  localparam int unsigned W    = CW * SIZE;

  logic          clk = 1'b0;
  logic          in_reset;
  logic [AW-1:0] in_address;
  logic [1:0]    in_type;
  logic [1:0]    in_matrix;
  logic          in_read_en;
  logic          in_write_en;
  logic [W-1:0]  in_data;
  logic [W-1:0]  out_data;
  logic          out_data_ready;
  logic          out_busy;
`ifdef MATRIX_BANK_RANGE_CHECK_EN
  logic          out_error;
`endif

  matrix_bank #(
    .size          (SIZE),
    .cell_width    (CW),
    .address_width (AW)
  ) dut (
    .in_clk         (clk),
    .in_reset       (in_reset),
    .in_address     (in_address),
    .in_type        (in_type),
    .in_matrix      (in_matrix),
    .in_read_en     (in_read_en),
    .in_write_en    (in_write_en),
    .in_data        (in_data),
`ifdef MATRIX_BANK_RANGE_CHECK_EN
    .out_error      (out_error),
`endif
    .out_data       (out_data),
    .out_data_ready (out_data_ready),
    .out_busy       (out_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           id;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   pcyc      = 0;
  int   issue_cyc = 0;
  int   pulses    = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Monitor: every ready pulse must match the oldest expected response, in data and latency.
  always @(negedge clk) begin
    exp_t e;
    if (out_data_ready) begin
      pulses++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: pulse with data %h and nothing expected", out_data);
      end else begin
        e = sb_q.pop_front();
        if (out_data !== e.data) begin
          errors++;
          $display("FAIL read%0d_data: got %h expected %h", e.id, out_data, e.data);
        end
        checks++;
        if (pcyc - issue_cyc != e.lat) begin
          errors++;
          $display("FAIL read%0d_latency: got %0d expected %0d", e.id, pcyc - issue_cyc, e.lat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a ready pulse; leaves the bench on the negedge where it was seen.
  task automatic wait_ready(input int id);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_data_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL read%0d_timeout: no ready pulse within 20 cycles", id);
    end
  endtask

  task automatic wr(input logic [1:0] m, input logic [AW-1:0] a, input logic [CW-1:0] d);
    in_write_en = 1'b1;
    in_type     = 2'(TYPE_CELL);
    in_matrix   = m;
    in_address  = a;
    in_data     = W'(d);
    @(negedge clk);
    in_write_en = 1'b0;
  endtask

  task automatic rd(input int id, input logic [1:0] t, input logic [1:0] m, input logic [AW-1:0] a,
                    input logic [W-1:0] exp_d, input int lat, input bit hold);
    exp_t e;
    e.data = exp_d;
    e.lat  = lat;
    e.id   = id;
    sb_q.push_back(e);
    in_type    = t;
    in_matrix  = m;
    in_address = a;
    issue_cyc  = pcyc;
    in_read_en = 1'b1;
    wait_ready(id);
    if (hold) @(negedge clk);
    in_read_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p0;
    in_reset    = 1'b1;
    in_address  = '0;
    in_type     = '0;
    in_matrix   = '0;
    in_read_en  = 1'b0;
    in_write_en = 1'b0;
    in_data     = '0;
    repeat (3) @(negedge clk);
    check("reset_data", out_data, '0);
    check("reset_ready", W'(out_data_ready), '0);
    check("reset_busy", W'(out_busy), '0);
`ifdef MATRIX_BANK_RANGE_CHECK_EN
    check("reset_error", W'(out_error), '0);
`endif
    in_reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) wr(2'(MAT_A), AW'(i), CW'(16'h0100 + i));

    rd(1, 2'(TYPE_ROW), 2'(MAT_A), AW'(8), 64'h010B_010A_0109_0108, 5, 1'b0);
    rd(2, 2'(TYPE_COL), 2'(MAT_A), AW'(2), 64'h010E_010A_0106_0102, 5, 1'b0);

    wr(2'(MAT_C), AW'(5), 16'h1234);
    rd(3, 2'(TYPE_CELL), 2'(MAT_C), AW'(5), 64'h0000_0000_0000_1234, 2, 1'b0);
    repeat (3) @(negedge clk);
    check("data_hold", out_data, 64'h0000_0000_0000_1234);

    // Requester keeps read_en high through RESPOND: still exactly one pulse.
    p0 = pulses;
    rd(4, 2'(TYPE_ROW), 2'(MAT_A), AW'(0), 64'h0103_0102_0101_0100, 5, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_one_pulse", W'(pulses - p0), W'(1));

    // Write and read together in IDLE: write wins, read is accepted one cycle later.
    begin
      exp_t e;
      e.data = 64'h0000_0000_0000_BEEF;
      e.lat  = 3;
      e.id   = 5;
      sb_q.push_back(e);
    end
    in_write_en = 1'b1;
    in_read_en  = 1'b1;
    in_type     = 2'(TYPE_CELL);
    in_matrix   = 2'(MAT_B);
    in_address  = AW'(3);
    in_data     = W'(16'hBEEF);
    issue_cyc   = pcyc;
    @(negedge clk);
    in_write_en = 1'b0;
    check("collide_not_started", W'(out_busy), '0);
    wait_ready(5);
    in_read_en = 1'b0;
    @(negedge clk);

    // Write landing on the beat that reads it returns the old value.
    begin
      exp_t e;
      e.data = 64'h0107_0106_0105_0104;
      e.lat  = 5;
      e.id   = 6;
      sb_q.push_back(e);
    end
    in_type    = 2'(TYPE_ROW);
    in_matrix  = 2'(MAT_A);
    in_address = AW'(4);
    issue_cyc  = pcyc;
    in_read_en = 1'b1;
    @(negedge clk);
    check("busy_in_gather", W'(out_busy), W'(1));
    in_write_en = 1'b1;
    in_data     = W'(16'hAAAA);
    @(negedge clk);
    in_write_en = 1'b0;
    wait_ready(6);
    in_read_en = 1'b0;
    @(negedge clk);
    rd(7, 2'(TYPE_CELL), 2'(MAT_A), AW'(4), 64'h0000_0000_0000_AAAA, 2, 1'b0);

    // Reserved type reads a single cell; invalid matrix reads zero.
    rd(8, 2'(TYPE_RSVD), 2'(MAT_A), AW'(5), 64'h0000_0000_0000_0105, 2, 1'b0);
    rd(9, 2'(TYPE_CELL), 2'(MAT_INVALID), AW'(5), 64'h0, 2, 1'b0);
`ifdef MATRIX_BANK_RANGE_CHECK_EN
    check("err_after_bad_matrix", W'(out_error), W'(1));
`endif
    rd(10, 2'(TYPE_ROW), 2'(MAT_INVALID), AW'(0), 64'h0, 5, 1'b0);

    // Write past the last cell is dropped; it must not alias onto B[0].
    wr(2'(MAT_A), AW'(16), 16'hDEAD);
`ifdef MATRIX_BANK_RANGE_CHECK_EN
    check("err_dropped_write", W'(out_error), W'(1));
`endif
    rd(11, 2'(TYPE_ROW), 2'(MAT_A), AW'(13), 64'h0000_010F_010E_010D, 5, 1'b0);
`ifdef MATRIX_BANK_RANGE_CHECK_EN
    check("err_row_overrun", W'(out_error), W'(1));
`endif
    rd(12, 2'(TYPE_ROW), 2'(MAT_B), AW'(0), 64'hBEEF_0000_0000_0000, 5, 1'b0);
`ifdef MATRIX_BANK_RANGE_CHECK_EN
    check("err_cleared", W'(out_error), '0);
`endif
    rd(13, 2'(TYPE_CELL), 2'(MAT_A), AW'(0), 64'h0000_0000_0000_0100, 2, 1'b0);

    // Reset at GATHER beat 2 aborts the read and clears the array.
    in_type    = 2'(TYPE_ROW);
    in_matrix  = 2'(MAT_A);
    in_address = AW'(0);
    in_read_en = 1'b1;
    repeat (3) @(negedge clk);
    in_reset   = 1'b1;
    in_read_en = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(out_busy), '0);
    check("abort_ready", W'(out_data_ready), '0);
    in_reset = 1'b0;
    repeat (8) @(negedge clk);
    rd(14, 2'(TYPE_ROW), 2'(MAT_A), AW'(0), 64'h0, 5, 1'b0);
    rd(15, 2'(TYPE_CELL), 2'(MAT_C), AW'(5), 64'h0, 2, 1'b0);
    rd(16, 2'(TYPE_COL), 2'(MAT_B), AW'(3), 64'h0, 5, 1'b0);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
